// File: rtl/conv_8x32_result_reader.sv
// Streams a convolution result set from a synchronous result memory onto a
// valid/ready interface, one word per FETCH/WAIT/HOLD round.
module conv_8x32_result_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] len_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  is_last;
  logic                  xfer;

  // Final word when idx reaches len-1 (wraps naturally at ADDR_WIDTH bits).
  assign is_last = (idx_q == (len_q - ADDR_WIDTH'(1)));
  assign xfer    = (state_q == S_HOLD) && ready_in;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start/len are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_in) state_d = (len_in == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_HOLD;
      S_HOLD:  if (ready_in) state_d = is_last ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: latch length on start, capture read data in WAIT, advance index on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      len_q  <= '0;
      data_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_in && len_in != '0) begin
        len_q <= len_in;
        idx_q <= '0;
      end
      if (state_q == S_WAIT) data_q <= mem_data_in;
      if (xfer && !is_last)  idx_q  <= idx_q + ADDR_WIDTH'(1);
    end
  end

  // Outputs decoded from registered state only.
  assign mem_rd_en_out = (state_q == S_FETCH);
  assign mem_addr_out  = (state_q == S_FETCH) ? idx_q : '0;
  assign data_out      = data_q;
  assign valid_out     = (state_q == S_HOLD);
  assign last_out      = (state_q == S_HOLD) && is_last;
  assign busy_out      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_HOLD);
  assign done_out      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_8x32_result_reader.sv
// Randomized bench for conv_8x32_result_reader; the reference is the word list
// mem[0..len-1] with last on the final entry, checked transfer by transfer.
module tb_conv_8x32_result_reader;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic [AW-1:0] len_in = '0;
  logic          mem_rd_en_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          last_out;
  logic          busy_out;
  logic          done_out;

  logic [DW-1:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  conv_8x32_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .len_in(len_in),
    .mem_rd_en_out(mem_rd_en_out), .mem_addr_out(mem_addr_out),
    .mem_data_in(mem_data_in), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .last_out(last_out), .busy_out(busy_out),
    .done_out(done_out)
  );

  always #5 clk = ~clk;

  // Synchronous result memory: data one cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en_out) mem_data_in <= mem[mem_addr_out];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
  endtask

  // Start a set of len words and follow it to completion. rdy_pct: chance
  // ready is high per cycle; stall: forced ready=0 cycles in the first HOLD;
  // mid_start: pulse a bogus start mid-stream.
  task automatic run_stream(input int len, input int rdy_pct, input int stall,
                            input bit mid_start, input bit chk_lat);
    int k = 0, rd_cnt = 0, cyc = 0, first_v = -1;
    bit stalled = 0, done_seen = 0, mid_done = 0;
    logic [DW-1:0] held = '0;
    start_in = 1'b1; len_in = AW'(len);
    @(negedge clk);
    start_in = 1'b0;
    if (len == 0) begin
      chk("zlen_done", done_out, 1);
      chk("zlen_busy", busy_out, 0);
      chk("zlen_rd", mem_rd_en_out, 0);
      chk("zlen_valid", valid_out, 0);
      @(negedge clk);
      chk("zlen_done_1cyc", done_out, 0);
      chk("zlen_rd2", mem_rd_en_out, 0);
      return;
    end
    while (!done_seen && cyc < 2000) begin
      if (start_in) begin start_in = 1'b0; len_in = '0; end
      if (mem_rd_en_out) begin
        chk("rd_addr", mem_addr_out, k);
        rd_cnt++;
      end
      if (stalled) begin
        chk("stall_valid", valid_out, 1);
        chk("stall_data", data_out, held);
      end
      if (valid_out && first_v < 0) first_v = cyc;
      if (done_out) begin
        done_seen = 1;
        chk("done_after_last", k, len);
        chk("done_busy", busy_out, 0);
        start_in = 1'b1; len_in = 6'd3;   // start during DONE must be ignored
        @(negedge clk);
        start_in = 1'b0; len_in = '0;
        chk("done_1cyc", done_out, 0);
        chk("post_done_busy", busy_out, 0);
        chk("post_done_rd", mem_rd_en_out, 0);
      end else begin
        chk("busy", busy_out, 1);
        if (!valid_out) chk("last_idle", last_out, 0);
        if (mid_start && !mid_done && k == 10) begin
          start_in = 1'b1; len_in = 6'd5; mid_done = 1;
        end
        if (valid_out && stall > 0) begin ready_in = 1'b0; stall--; end
        else ready_in = ($urandom_range(99) < rdy_pct);
        stalled = valid_out && !ready_in;
        held = data_out;
        if (valid_out && ready_in) begin
          chk("xfer_data", data_out, mem[k]);
          chk("xfer_last", last_out, (k == len - 1));
          k++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("stream_timeout", done_seen, 1);
    chk("n_words", k, len);
    chk("n_reads", rd_cnt, len);
    if (chk_lat) chk("first_valid_lat", first_v, 2);
    ready_in = 1'b0;
  endtask

  initial begin
    int nv;
    // Reset state
    #2;
    chk("rst_rd", mem_rd_en_out, 0); chk("rst_addr", mem_addr_out, 0);
    chk("rst_data", data_out, 0);    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", busy_out, 0);
      chk("idle_rd", mem_rd_en_out, 0);
    end

    // Basic three-word set
    fill_rand();
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033;
    run_stream(3, 100, 0, 0, 1);
    // Backpressure in first HOLD
    fill_rand();
    run_stream(2, 100, 5, 0, 1);
    // Zero length
    run_stream(0, 100, 0, 0, 0);
    // Full set with a start mid-stream
    fill_rand();
    run_stream(39, 100, 0, 1, 1);
    // Single word
    fill_rand();
    run_stream(1, 100, 0, 0, 1);

    // Reset during HOLD of word 4
    fill_rand();
    ready_in = 1'b1;
    start_in = 1'b1; len_in = 6'd8;
    @(negedge clk);
    start_in = 1'b0;
    nv = 0;
    for (int c = 0; c < 100; c++) begin
      if (valid_out) begin
        if (nv == 4) break;
        nv++;
      end
      @(negedge clk);
    end
    chk("rst_reach_word4", valid_out, 1);
    chk("rst_word4_data", data_out, mem[4]);
    ready_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_rd", mem_rd_en_out, 0); chk("mrst_addr", mem_addr_out, 0);
    chk("mrst_data", data_out, 0);    chk("mrst_valid", valid_out, 0);
    chk("mrst_last", last_out, 0);    chk("mrst_busy", busy_out, 0);
    chk("mrst_done", done_out, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mrst_idle_busy", busy_out, 0);
      chk("mrst_idle_rd", mem_rd_en_out, 0);
    end
    run_stream(3, 100, 0, 0, 1);

    // Random sets with random backpressure
    for (int t = 0; t < 12; t++) begin
      fill_rand();
      run_stream($urandom_range(63), $urandom_range(20, 100), $urandom_range(3), 0, 0);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_8x32_result_reader.md
CONV_8X32_RESULT_READER -- requirements
Module: conv_8x32_result_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one convolution result word and of mem_data_in/data_out.
REQ-002 Parameter ADDR_WIDTH, default 6: width of mem_addr_out and len_in; the full 8x32 result set is 39 words.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port start_in, input, 1: request to stream a result set; sampled only in IDLE.
REQ-006 Port len_in, input, ADDR_WIDTH: number of result words to stream; latched on an accepted start.
REQ-007 Port mem_rd_en_out, output, 1: result-memory read strobe.
REQ-008 Port mem_addr_out, output, ADDR_WIDTH: result-memory read address.
REQ-009 Port mem_data_in, input, DATA_WIDTH: read data; valid exactly one cycle after mem_rd_en_out=1.
REQ-010 Port data_out, output, DATA_WIDTH: streamed result word.
REQ-011 Port valid_out, output, 1: data_out holds a valid word.
REQ-012 Port ready_in, input, 1: downstream accepts; transfer occurs when valid_out=1 and ready_in=1 on a rising edge.
REQ-013 Port last_out, output, 1: qualifies the final word of the set; meaningful only with valid_out=1.
REQ-014 Port busy_out, output, 1: high in FETCH, WAIT and HOLD.
REQ-015 Port done_out, output, 1: one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, WAIT, HOLD and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-017 In IDLE with start_in=1 and len_in!=0, the block SHALL latch len_in into len_q, clear index idx to 0 and go to FETCH.
REQ-018 In IDLE with start_in=1 and len_in=0, the block SHALL go directly to DONE, with no memory read and no valid_out.
REQ-019 In FETCH, mem_rd_en_out SHALL be 1 and mem_addr_out SHALL equal idx for exactly that cycle; next state is WAIT.
REQ-020 In WAIT, mem_data_in SHALL be captured into data_out at the cycle end; next state is HOLD.
REQ-021 In HOLD, valid_out SHALL be 1 and data_out SHALL stay stable until the transfer; last_out SHALL be 1 when idx == len_q-1 (equality compare, ADDR_WIDTH bits).
REQ-022 In HOLD, on transfer with last_out=0, the block SHALL increment idx and go to FETCH; with last_out=1 it SHALL go to DONE.
REQ-023 In HOLD with ready_in=0, the block SHALL remain in HOLD indefinitely with valid_out, data_out and last_out unchanged.
REQ-024 In DONE, done_out SHALL be 1 for exactly one cycle; next state is IDLE.
REQ-025 start_in and len_in SHALL be ignored outside IDLE; a start during DONE SHALL be ignored.
REQ-026 Timing: start accepted at edge E gives FETCH in cycle E+1, first valid_out in cycle E+3; with ready_in held at 1, the sustained rate is one word per 3 cycles.
REQ-027 mem_rd_en_out, valid_out, last_out and done_out SHALL be 0 in every state other than those stated above.

Reset
REQ-028 On rst_n=0, at any time including mid-stream, the block SHALL go to IDLE and all of the following SHALL be 0: mem_rd_en_out, mem_addr_out, data_out, valid_out, last_out, busy_out, done_out, idx and len_q.
REQ-029 After rst_n is released, the first state change SHALL occur on the first rising edge with start_in=1.

Verification
REQ-030 Set len_in=3 with memory [0]=0x0011, [1]=0x0022, [2]=0x0033 and ready_in=1, then pulse start -> words 0x0011, 0x0022, 0x0033 are streamed; last_out=1 only on 0x0033; done_out pulses once the cycle after the final transfer.
REQ-031 Set len_in=2 and hold ready_in=0 for 5 cycles in the first HOLD -> valid_out=1 and data_out stay stable for all 5 cycles; no extra memory read occurs; the stream then completes normally.
REQ-032 Set len_in=0 and pulse start -> no mem_rd_en_out and no valid_out; done_out=1 in the next cycle; busy_out stays 0.
REQ-033 With len_in=39 streaming, pulse start with len_in=5 mid-stream -> it is ignored; exactly 39 words are sent, with addresses 0..38 and last_out on address 38.
REQ-034 Assert rst_n=0 in HOLD of word 4 -> all outputs are 0 immediately; after release with start_in=0, the block stays idle; a new start restarts at address 0.
REQ-035 Use len_in=1 -> a single word is sent with last_out=1 on the same transfer, followed by done_out.
